// File: rtl/calc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : calc_stack
//  Brief    : RPN calculator core. It holds an operand stack of DEPTH entries,
//             each WIDTH bits wide. A single-cycle ALU handles add, sub, logic,
//             shift and compare. An iterative shift-add multiplier handles MUL.
//             Commands arrive through a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module calc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [3:0]                   cmd_op,
    input  logic [WIDTH-1:0]             cmd_data,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         flag_c,
    output logic                         flag_z,
    output logic                         err_ovf,
    output logic                         err_unf,
    output logic                         err_ill
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(WIDTH);

    localparam logic [DW-1:0]    c_full   = DW'(DEPTH);
    localparam logic [CW-1:0]    c_last   = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_width  = WIDTH'(WIDTH);

    localparam logic [3:0] c_op_push = 4'h0;
    localparam logic [3:0] c_op_pop  = 4'h1;
    localparam logic [3:0] c_op_dup  = 4'h2;
    localparam logic [3:0] c_op_swap = 4'h3;
    localparam logic [3:0] c_op_add  = 4'h4;
    localparam logic [3:0] c_op_sub  = 4'h5;
    localparam logic [3:0] c_op_and  = 4'h6;
    localparam logic [3:0] c_op_or   = 4'h7;
    localparam logic [3:0] c_op_xor  = 4'h8;
    localparam logic [3:0] c_op_sll  = 4'h9;
    localparam logic [3:0] c_op_sra  = 4'hA;
    localparam logic [3:0] c_op_slt  = 4'hB;
    localparam logic [3:0] c_op_mul  = 4'hC;
    localparam logic [3:0] c_op_clr  = 4'hD;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_stack [DEPTH];
    logic [DW-1:0]      r_depth;
    logic               r_flag_c;
    logic               r_err_ovf;
    logic               r_err_unf;
    logic               r_err_ill;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [WIDTH-1:0]   r_mul_acc;
    logic [CW-1:0]      r_mul_cnt;

    logic               w_accept;
    logic               w_empty;
    logic               w_full;
    logic               w_ge2;
    logic [IW-1:0]      w_ti;
    logic [IW-1:0]      w_ni;
    logic [IW-1:0]      w_pi;
    logic [WIDTH-1:0]   w_t;
    logic [WIDTH-1:0]   w_n;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;
    logic [WIDTH:0]     w_wide;
    logic [WIDTH-1:0]   w_mul_step;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_empty  = (r_depth == '0);
    assign w_full   = (r_depth == c_full);
    assign w_ge2    = (r_depth >= DW'(2));

    // Indices of T, N and the next free slot. They wrap harmlessly when the
    // stack is too shallow, because every use of them is gated by a depth check.
    assign w_ti = IW'(r_depth - DW'(1));
    assign w_ni = IW'(r_depth - DW'(2));
    assign w_pi = IW'(r_depth);
    assign w_t  = r_stack[w_ti];
    assign w_n  = r_stack[w_ni];

    // One multiplier step: add the shifted multiplicand when the low multiplier bit is set.
    assign w_mul_step = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);

    // Single-cycle ALU: computes the result of the binary op from N and T.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_wide    = '0;
        case (cmd_op)
            c_op_add: begin
                w_wide    = {1'b0, w_n} + {1'b0, w_t};
                w_alu_res = w_wide[WIDTH-1:0];
                w_alu_c   = w_wide[WIDTH];
            end
            c_op_sub: begin
                w_wide    = {1'b0, w_n} - {1'b0, w_t};
                w_alu_res = w_wide[WIDTH-1:0];
                w_alu_c   = w_wide[WIDTH];
            end
            c_op_and: w_alu_res = w_n & w_t;
            c_op_or:  w_alu_res = w_n | w_t;
            c_op_xor: w_alu_res = w_n ^ w_t;
            c_op_sll: w_alu_res = (w_t >= c_width) ? '0 : (w_n << w_t);
            c_op_sra: w_alu_res = (w_t >= c_width) ? {WIDTH{w_n[WIDTH-1]}}
                                                   : WIDTH'($signed(w_n) >>> w_t);
            c_op_slt: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(w_n) < $signed(w_t))};
            default:  w_alu_res = '0;
        endcase
    end

    // Command FSM: executes single-cycle ops directly, and steps the multiplier while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_depth   <= '0;
            r_flag_c  <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            r_err_ill <= 1'b0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_mul_acc <= '0;
            r_mul_cnt <= '0;
        end else if (r_state == S_MUL_BUSY) begin
            r_mul_acc <= w_mul_step;
            r_mul_a   <= r_mul_a << 1;
            r_mul_b   <= r_mul_b >> 1;
            r_mul_cnt <= r_mul_cnt + 1'b1;
            if (r_mul_cnt == c_last) begin
                r_stack[w_ni] <= w_mul_step;
                r_depth       <= r_depth - 1'b1;
                r_state       <= S_IDLE;
            end
        end else if (w_accept) begin
            case (cmd_op)
                c_op_push: begin
                    if (w_full) begin
                        r_err_ovf <= 1'b1;
                    end else begin
                        r_stack[w_pi] <= cmd_data;
                        r_depth       <= r_depth + 1'b1;
                    end
                end
                c_op_pop: begin
                    if (w_empty) r_err_unf <= 1'b1;
                    else         r_depth   <= r_depth - 1'b1;
                end
                c_op_dup: begin
                    if (w_empty) begin
                        r_err_unf <= 1'b1;
                    end else if (w_full) begin
                        r_err_ovf <= 1'b1;
                    end else begin
                        r_stack[w_pi] <= w_t;
                        r_depth       <= r_depth + 1'b1;
                    end
                end
                c_op_swap: begin
                    if (!w_ge2) begin
                        r_err_unf <= 1'b1;
                    end else begin
                        r_stack[w_ti] <= w_n;
                        r_stack[w_ni] <= w_t;
                    end
                end
                c_op_add, c_op_sub, c_op_and, c_op_or,
                c_op_xor, c_op_sll, c_op_sra, c_op_slt: begin
                    if (!w_ge2) begin
                        r_err_unf <= 1'b1;
                    end else begin
                        r_stack[w_ni] <= w_alu_res;
                        r_depth       <= r_depth - 1'b1;
                        if ((cmd_op == c_op_add) || (cmd_op == c_op_sub)) begin
                            r_flag_c <= w_alu_c;
                        end
                    end
                end
                c_op_mul: begin
                    if (!w_ge2) begin
                        r_err_unf <= 1'b1;
                    end else begin
                        r_mul_a   <= w_n;
                        r_mul_b   <= w_t;
                        r_mul_acc <= '0;
                        r_mul_cnt <= '0;
                        r_state   <= S_MUL_BUSY;
                    end
                end
                c_op_clr: begin
                    r_depth   <= '0;
                    r_flag_c  <= 1'b0;
                    r_err_ovf <= 1'b0;
                    r_err_unf <= 1'b0;
                    r_err_ill <= 1'b0;
                end
                default: r_err_ill <= 1'b1;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign top       = w_empty ? '0 : w_t;
    assign depth     = r_depth;
    assign flag_c    = r_flag_c;
    assign flag_z    = !w_empty && (top == '0);
    assign err_ovf   = r_err_ovf;
    assign err_unf   = r_err_unf;
    assign err_ill   = r_err_ill;

endmodule
`default_nettype wire
